// File: rtl/slow_vram_pkg.sv
// Shared slot encodings, slot kinds and the registered control word of the slow VRAM scheduler.
package slow_vram_pkg;

  localparam logic [1:0] SLOT_FIX      = 2'd0;
  localparam logic [1:0] SLOT_SPR_EVEN = 2'd1;
  localparam logic [1:0] SLOT_SPR_ODD  = 2'd2;
  localparam logic [1:0] SLOT_CPU      = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } slot_kind_e;

  // Everything the scheduler drives toward the VRAM and the requester, registered as one word.
  // latch[i] is the capture strobe for slot i.
  typedef struct packed {
    logic       n_boe;
    logic       n_bwe;
    logic       data_oe;
    logic [3:0] latch;
    logic       wr_done;
    logic       wr_busy;
  } vram_ctl_t;

  localparam vram_ctl_t CTL_RESET = '{
    n_boe:   1'b1,
    n_bwe:   1'b1,
    data_oe: 1'b0,
    latch:   4'd0,
    wr_done: 1'b0,
    wr_busy: 1'b0
  };

endpackage

// File: rtl/slow_vram_slot_ctr.sv
// Phase/slot counter: PH walks 0..SLOT_CYCLES-1, SLOT advances mod 4 at each phase wrap.
// Also exposes the next-state values so the top can register decode aligned with the counter.
module slow_vram_slot_ctr #(
  parameter  int unsigned SLOT_CYCLES = 4,
  localparam int unsigned PH_W        = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            sync_i,
  output logic [1:0]      slot_o,
  output logic [1:0]      slot_nxt_c,
  output logic [PH_W-1:0] ph_nxt_c,
  output logic            slot_start_c,
  output logic            slot_last_c
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_CYCLES - 1);

  logic [PH_W-1:0] ph_q, ph_d;
  logic [1:0]      slot_q, slot_d;

  // Next phase/slot; realignment wins over normal counting.
  always_comb begin
    ph_d        = ph_q + PH_W'(1);
    slot_d      = slot_q;
    slot_last_c = (ph_q == PH_LAST);
    if (sync_i) begin
      ph_d   = '0;
      slot_d = '0;
    end else if (slot_last_c) begin
      ph_d   = '0;
      slot_d = slot_q + 2'd1;
    end
    slot_start_c = (ph_d == '0);
    slot_nxt_c   = slot_d;
    ph_nxt_c     = ph_d;
  end

  // Counter state; reset has priority over realignment.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ph_q   <= '0;
      slot_q <= '0;
    end else begin
      ph_q   <= ph_d;
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/slow_vram_sched.sv
// Slow VRAM access-slot scheduler: FIX / SPR even / SPR odd / CPU slots, each SLOT_CYCLES long,
// with registered VRAM strobes and the CPU write-pending handshake serviced in the CPU slot.
module slow_vram_sched
  import slow_vram_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = 4,
  parameter int unsigned WE_FIRST    = 1,
  parameter int unsigned WE_LAST     = 2
) (
  input  logic       clk_24m_i,
  input  logic       nreset_i,
  input  logic       seq_sync_i,
  input  logic       fix_en_i,
  input  logic       spr_en_i,
  input  logic       n_vram_write_req_i,
  input  logic       reg_vramaddr_msb_i,
  output logic [1:0] slot_sel_o,
  output logic       n_boe_o,
  output logic       n_bwe_o,
  output logic       data_oe_o,
  output logic       latch_fix_o,
  output logic       latch_spr_even_o,
  output logic       latch_spr_odd_o,
  output logic       latch_cpu_o,
  output logic       wr_busy_o,
  output logic       wr_done_o
);

  localparam int unsigned     PH_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_WE_F = PH_W'(WE_FIRST);
  localparam logic [PH_W-1:0] PH_WE_L = PH_W'(WE_LAST);

  logic [1:0]      slot_cur;
  logic [1:0]      slot_nxt;
  logic [PH_W-1:0] ph_nxt;
  logic            slot_start;
  logic            slot_last;

  slot_kind_e      kind_q, kind_d;
  logic            pending_q, pending_d;
  logic [1:0]      slot_sel_q, slot_sel_d;
  vram_ctl_t       ctl_q, ctl_d;
  logic            wr_set;
  logic            wr_clr;

  slow_vram_slot_ctr #(
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_ctr (
    .clk_i        (clk_24m_i),
    .rst_n_i      (nreset_i),
    .sync_i       (seq_sync_i),
    .slot_o       (slot_cur),
    .slot_nxt_c   (slot_nxt),
    .ph_nxt_c     (ph_nxt),
    .slot_start_c (slot_start),
    .slot_last_c  (slot_last)
  );

  // Slot kind, pending flag and the control word for the cycle being entered.
  always_comb begin
    kind_d     = kind_q;
    pending_d  = pending_q;
    slot_sel_d = slot_sel_q;
    ctl_d      = CTL_RESET;

    // Enables and the pending flag are frozen for the slot on the edge that enters its PH0.
    if (slot_start) begin
      slot_sel_d = slot_nxt;
      case (slot_nxt)
        SLOT_FIX:      kind_d = fix_en_i ? READ : IDLE;
        SLOT_SPR_EVEN: kind_d = spr_en_i ? READ : IDLE;
        SLOT_SPR_ODD:  kind_d = spr_en_i ? READ : IDLE;
        default:       kind_d = pending_q ? WRITE : READ;
      endcase
    end else begin
      slot_sel_d = slot_cur;
    end

    // A new request on the committing edge re-arms the flag instead of being lost.
    wr_set = !n_vram_write_req_i && !reg_vramaddr_msb_i;
    wr_clr = (kind_q == WRITE) && slot_last;
    if (wr_clr) begin
      pending_d = wr_set;
    end else if (wr_set) begin
      pending_d = 1'b1;
    end

    case (kind_d)
      READ: begin
        ctl_d.n_boe          = (ph_nxt == '0);
        ctl_d.latch[slot_nxt] = (ph_nxt == PH_LAST);
      end
      WRITE: begin
        ctl_d.data_oe = 1'b1;
        ctl_d.n_bwe   = !((ph_nxt >= PH_WE_F) && (ph_nxt <= PH_WE_L));
        ctl_d.wr_done = (ph_nxt == PH_LAST);
      end
      default: ;
    endcase
    ctl_d.wr_busy = pending_d || (kind_d == WRITE);
  end

  // Registered state and outputs; reset is treated as entering FIX PH0.
  always_ff @(posedge clk_24m_i) begin
    if (!nreset_i) begin
      kind_q     <= fix_en_i ? READ : IDLE;
      pending_q  <= 1'b0;
      slot_sel_q <= SLOT_FIX;
      ctl_q      <= CTL_RESET;
    end else begin
      kind_q     <= kind_d;
      pending_q  <= pending_d;
      slot_sel_q <= slot_sel_d;
      ctl_q      <= ctl_d;
    end
  end

  assign slot_sel_o       = slot_sel_q;
  assign n_boe_o          = ctl_q.n_boe;
  assign n_bwe_o          = ctl_q.n_bwe;
  assign data_oe_o        = ctl_q.data_oe;
  assign latch_fix_o      = ctl_q.latch[SLOT_FIX];
  assign latch_spr_even_o = ctl_q.latch[SLOT_SPR_EVEN];
  assign latch_spr_odd_o  = ctl_q.latch[SLOT_SPR_ODD];
  assign latch_cpu_o      = ctl_q.latch[SLOT_CPU];
  assign wr_busy_o        = ctl_q.wr_busy;
  assign wr_done_o        = ctl_q.wr_done;

endmodule
